// File: rtl/five_bit_acc_seq.sv
// five_bit_acc_seq: 5-bit add/subtract/load accumulator with a three-state
// command/result handshake (IDLE -> EXEC -> HOLD).
// Optional macro FIVE_BIT_ACC_OVF_EN adds a sticky signed-overflow output res_ovf.
module five_bit_acc_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_op,
   input  logic       cmd_clr,
   input  logic [4:0] cmd_data,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [4:0] res_data,
`ifdef FIVE_BIT_ACC_OVF_EN
   output logic       res_ovf,
`endif
   output logic       res_carry
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t     r_state;
   logic       r_op;
   logic       r_clr;
   logic [4:0] r_data;
   logic [4:0] r_acc;
   logic       r_carry;
   logic       r_cmd_ready;
   logic       r_res_valid;

   // Subtract is acc + ~data + 1, so the operand is conditionally inverted
   // and the op bit doubles as the carry-in.
   logic [4:0] w_opnd;
   logic [5:0] w_sum;

   assign w_opnd = r_data ^ {5{r_op}};
   assign w_sum  = {1'b0, r_acc} + {1'b0, w_opnd} + {5'd0, r_op};

`ifdef FIVE_BIT_ACC_OVF_EN
   logic r_ovf;
   logic w_ovf;

   // Signed overflow: both addends share a sign and the result sign differs.
   assign w_ovf   = (r_acc[4] == w_opnd[4]) && (w_sum[4] != r_acc[4]);
   assign res_ovf = r_ovf;
`endif

   assign cmd_ready = r_cmd_ready;
   assign res_valid = r_res_valid;
   assign res_data  = r_acc;
   assign res_carry = r_carry;

   // Control FSM, command capture, and accumulator update.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_op        <= 1'b0;
         r_clr       <= 1'b0;
         r_data      <= 5'd0;
         r_acc       <= 5'd0;
         r_carry     <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_res_valid <= 1'b0;
`ifdef FIVE_BIT_ACC_OVF_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_op        <= cmd_op;
                  r_clr       <= cmd_clr;
                  r_data      <= cmd_data;
                  r_cmd_ready <= 1'b0;
                  r_state     <= EXEC;
               end
            end
            EXEC: begin
               if (r_clr) begin
                  r_acc   <= r_data;
                  r_carry <= 1'b0;
`ifdef FIVE_BIT_ACC_OVF_EN
                  r_ovf   <= 1'b0;
`endif
               end else begin
                  r_acc   <= w_sum[4:0];
                  r_carry <= w_sum[5];
`ifdef FIVE_BIT_ACC_OVF_EN
                  r_ovf   <= r_ovf | w_ovf;
`endif
               end
               r_res_valid <= 1'b1;
               r_state     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_res_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_five_bit_acc_seq.sv
// Bench for five_bit_acc_seq: directed vector table, hold/reset sequences,
// then random commands checked against an arithmetic reference model.
module tb_five_bit_acc_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_op;
   logic       cmd_clr;
   logic [4:0] cmd_data;
   logic       res_valid;
   logic       res_ready;
   logic [4:0] res_data;
   logic       res_carry;
`ifdef FIVE_BIT_ACC_OVF_EN
   logic       res_ovf;
`endif

   int n_vec  = 0;
   int n_fail = 0;

   // reference model state
   int m_acc   = 0;
   int m_carry = 0;
   int m_ovf   = 0;

   five_bit_acc_seq dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_clr   (cmd_clr),
      .cmd_data  (cmd_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
`ifdef FIVE_BIT_ACC_OVF_EN
      .res_ovf   (res_ovf),
`endif
      .res_carry (res_carry)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int to_signed5(input int v);
      return (v >= 16) ? v - 32 : v;
   endfunction

   // Plain-arithmetic model of one command.
   task automatic model_step(input bit op, input bit clr, input int d);
      int s;
      if (clr) begin
         m_acc = d; m_carry = 0; m_ovf = 0;
      end else if (!op) begin
         s = to_signed5(m_acc) + to_signed5(d);
         if (s > 15 || s < -16) m_ovf = 1;
         m_carry = (m_acc + d >= 32) ? 1 : 0;
         m_acc   = (m_acc + d) % 32;
      end else begin
         s = to_signed5(m_acc) - to_signed5(d);
         if (s > 15 || s < -16) m_ovf = 1;
         m_carry = (m_acc >= d) ? 1 : 0;
         m_acc   = (m_acc - d + 32) % 32;
      end
   endtask

   // One full command handshake; inputs driven and outputs sampled at negedge.
   task automatic run_cmd(input bit op, input bit clr, input int d, input int hold,
                          input int exp_d, input int exp_c, input int exp_o);
      chk("idle_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_clr = clr; cmd_data = d[4:0];
      res_ready = $urandom_range(0, 1);
      @(posedge clk); @(negedge clk);
      chk("exec_cmd_ready", cmd_ready, 0);
      chk("exec_res_valid", res_valid, 0);
      // command inputs are don't-care now; scramble them
      cmd_valid = $urandom_range(0, 1); cmd_op = $urandom_range(0, 1);
      cmd_clr = $urandom_range(0, 1); cmd_data = $urandom_range(0, 31);
      res_ready = $urandom_range(0, 1);
      @(posedge clk); @(negedge clk);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, exp_d);
      chk("hold_res_carry", res_carry, exp_c);
`ifdef FIVE_BIT_ACC_OVF_EN
      chk("hold_res_ovf", res_ovf, exp_o);
`endif
      for (int h = 0; h < hold; h++) begin
         res_ready = 1'b0;
         cmd_valid = $urandom_range(0, 1);
         @(posedge clk); @(negedge clk);
         chk("stall_res_valid", res_valid, 1);
         chk("stall_cmd_ready", cmd_ready, 0);
         chk("stall_res_data", res_data, exp_d);
         chk("stall_res_carry", res_carry, exp_c);
      end
      res_ready = 1'b1; cmd_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      res_ready = 1'b0;
      chk("post_res_valid", res_valid, 0);
      chk("post_res_data", res_data, exp_d);
      if (exp_o < 0) chk("post_dummy_ovf", 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst = 1'b0;
      m_acc = 0; m_carry = 0; m_ovf = 0;
   endtask

   typedef struct {
      bit op;
      bit clr;
      int data;
      int exp_d;
      int exp_c;
   } vec_t;

   vec_t vt[$];

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_clr = 1'b0;
      cmd_data = 5'd0; res_ready = 1'b0;
      @(negedge clk);
      do_reset();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_carry", res_carry, 0);

      // directed vectors, incl. wrap corners 31+1 and 0-1
      vt.push_back('{0, 1, 5, 5, 0});
      vt.push_back('{0, 0, 3, 8, 0});
      vt.push_back('{0, 1, 30, 30, 0});
      vt.push_back('{0, 0, 5, 3, 1});
      vt.push_back('{1, 0, 5, 30, 0});
      vt.push_back('{1, 1, 3, 3, 0});
      vt.push_back('{1, 0, 3, 0, 1});
      vt.push_back('{1, 0, 1, 31, 0});
      vt.push_back('{0, 0, 1, 0, 1});
      vt.push_back('{0, 1, 31, 31, 0});
      vt.push_back('{0, 0, 0, 31, 0});
      foreach (vt[i]) begin
         model_step(vt[i].op, vt[i].clr, vt[i].data);
         run_cmd(vt[i].op, vt[i].clr, vt[i].data, (i == 1) ? 4 : 0,
                 vt[i].exp_d, vt[i].exp_c, m_ovf);
      end

      // reset during EXEC of "add 7": no result, acc cleared
      model_step(0, 1, 9);
      run_cmd(0, 1, 9, 0, m_acc, m_carry, m_ovf);
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_clr = 1'b0; cmd_data = 5'd7;
      @(posedge clk); @(negedge clk);
      chk("rexec_in_exec", cmd_ready, 0);
      cmd_valid = 1'b0; rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      m_acc = 0; m_carry = 0; m_ovf = 0;
      chk("rexec_cmd_ready", cmd_ready, 1);
      chk("rexec_res_valid", res_valid, 0);
      chk("rexec_res_data", res_data, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         chk("rexec_no_result", res_valid, 0);
      end

      // reset in HOLD overrides a simultaneous res_ready handshake
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_clr = 1'b1; cmd_data = 5'd12;
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rhold_valid", res_valid, 1);
      chk("rhold_data", res_data, 12);
      rst = 1'b1; res_ready = 1'b1; cmd_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0; res_ready = 1'b0; cmd_valid = 1'b0;
      chk("rhold_cmd_ready", cmd_ready, 1);
      chk("rhold_res_valid", res_valid, 0);
      chk("rhold_res_data", res_data, 0);
      chk("rhold_res_carry", res_carry, 0);

`ifdef FIVE_BIT_ACC_OVF_EN
      model_step(0, 1, 15); run_cmd(0, 1, 15, 0, 15, 0, 0);
      model_step(0, 0, 1);  run_cmd(0, 0, 1, 0, 16, 0, 1);
      model_step(0, 0, 1);  run_cmd(0, 0, 1, 0, 17, 0, 1);
      model_step(0, 1, 0);  run_cmd(0, 1, 0, 0, 0, 0, 0);
`endif

      // random commands against the model
      for (int n = 0; n < 300; n++) begin
         bit rop, rclr;
         int rd, rh;
         rop  = $urandom_range(0, 1);
         rclr = ($urandom_range(0, 7) == 0);
         rd   = $urandom_range(0, 31);
         rh   = $urandom_range(0, 3);
         if (n % 2 == 0) begin
            // idle bubble; res_ready outside HOLD must do nothing
            res_ready = $urandom_range(0, 1);
            @(posedge clk); @(negedge clk);
            res_ready = 1'b0;
            chk("rnd_idle_valid", res_valid, 0);
         end
         model_step(rop, rclr, rd);
         run_cmd(rop, rclr, rd, rh, m_acc, m_carry, m_ovf);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
